// File: rtl/inverse_zigzag_stream_pkg.sv
// Shared constants and types for the inverse zigzag reorder: block size, zigzag-to-raster LUT,
// and the per-bank buffer state.
package inverse_zigzag_stream_pkg;

  localparam int BLK_SIZE = 64;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  // Entry k is the raster address (8*row + col) of the k-th coefficient in zigzag scan order.
  localparam logic [5:0] ZZ_TO_RASTER [BLK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] zz_to_raster(input logic [5:0] zz_idx);
    return ZZ_TO_RASTER[zz_idx];
  endfunction

endpackage

// File: rtl/inverse_zigzag_stream_if.sv
// Coefficient stream bundle: zigzag-order input handshake, raster-order output handshake
// and the block-alignment error pulse.
interface inverse_zigzag_stream_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic          out_last;
  logic          blk_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, blk_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, blk_err
  );
endinterface

// File: rtl/dezz_bank_ram.sv
// 64 x DW simple dual-port block buffer: one write port, one synchronous read port whose
// output register holds its value while i_re is low (acts as the output skid stage).
module dezz_bank_ram #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [5:0]    i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [5:0]    i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [64];
  logic [DW-1:0] r_rdata;

  // NOTE: the storage array is deliberately left without reset so it maps onto RAM; only the
  // read register is reset, which is what the outside world can observe.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inverse_zigzag_stream.sv
// Zigzag-to-raster reorder buffer for 8x8 coefficient blocks. Define DEZIGZAG_PINGPONG_EN for
// two ping-pong banks (fill overlaps drain); otherwise a single bank alternates fill and drain.
module inverse_zigzag_stream
  import inverse_zigzag_stream_pkg::*;
#(
  parameter int DW  = 8,
  parameter int BLK = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  inverse_zigzag_stream_if.slave bus
);

`ifdef DEZIGZAG_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam bit         PINGPONG = (NB == 2);
  localparam logic [5:0] LAST_IDX = 6'(BLK - 1);

  bank_state_t   r_state     [2];
  bank_state_t   w_state_nxt [2];
  logic [DW-1:0] w_rdata     [2];

  logic       r_wr_bank;
  logic [5:0] r_wr_idx;
  logic       r_blk_err;
  logic       r_rd_active;
  logic       r_rd_bank;
  logic [5:0] r_rd_idx;
  logic       r_out_valid;
  logic       r_out_bank;
  logic [5:0] r_out_idx;

  logic       w_in_ready;
  logic       w_in_fire;
  logic       w_close;
  logic [5:0] w_waddr;
  logic       w_slot_free;
  logic       w_take;
  logic       w_issue;
  logic       w_out_done;

  assign w_in_ready = (r_state[r_wr_bank] == EMPTY) || (r_state[r_wr_bank] == FILLING);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  // A block closes on the 64th beat or on an early in_last, whichever comes first.
  assign w_close    = w_in_fire && (bus.in_last || (r_wr_idx == LAST_IDX));
  assign w_waddr    = zz_to_raster(r_wr_idx);

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_take      = !r_rd_active && (r_state[r_rd_bank] == FULL) && w_slot_free;
  assign w_issue     = w_slot_free && (r_rd_active || (r_state[r_rd_bank] == FULL));
  assign w_out_done  = r_out_valid && bus.out_ready && (r_out_idx == LAST_IDX);

  // NOTE: every combinational output gets its default first, so no path can infer a latch.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_in_fire && (r_wr_bank == 1'(b)))   w_state_nxt[b] = w_close ? FULL : FILLING;
      if (w_take && (r_rd_bank == 1'(b)))      w_state_nxt[b] = DRAINING;
      if (w_out_done && (r_out_bank == 1'(b))) w_state_nxt[b] = EMPTY;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) r_state[b] <= EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) r_state[b] <= w_state_nxt[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_blk_err <= 1'b0;
    end else begin
      r_blk_err <= w_in_fire && (bus.in_last != (r_wr_idx == LAST_IDX));
      if (w_close) begin
        r_wr_idx  <= '0;
        r_wr_bank <= PINGPONG ? ~r_wr_bank : 1'b0;
      end else if (w_in_fire) begin
        r_wr_idx  <= r_wr_idx + 6'd1;
      end
    end
  end

  // The RAM read register of the selected bank is the output data stage; it only advances on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_active <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_bank  <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_bank  <= r_rd_bank;
      r_out_idx   <= r_rd_idx;
      if (r_rd_idx == LAST_IDX) begin
        r_rd_active <= 1'b0;
        r_rd_idx    <= '0;
        r_rd_bank   <= PINGPONG ? ~r_rd_bank : 1'b0;
      end else begin
        r_rd_active <= 1'b1;
        r_rd_idx    <= r_rd_idx + 6'd1;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NB) begin : g_ram
      dezz_bank_ram #(.DW(DW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_in_fire && (r_wr_bank == 1'(b))),
        .i_waddr (w_waddr),
        .i_wdata (bus.in_data),
        .i_re    (w_issue && (r_rd_bank == 1'(b))),
        .i_raddr (r_rd_idx),
        .o_rdata (w_rdata[b])
      );
    end else begin : g_none
      assign w_rdata[b] = '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_bank ? w_rdata[1] : w_rdata[0];
  assign bus.out_row   = r_out_idx[5:3];
  assign bus.out_col   = r_out_idx[2:0];
  assign bus.out_last  = r_out_valid && (r_out_idx == LAST_IDX);
  assign bus.blk_err   = r_blk_err;

endmodule
